cache_controller: RTL and testbench
===================================

Name: cache_controller

Overview:
- Sits between the MEM stage and the external SRAM controller.
- Drives the 2-way, 64-set, 64-bit-line data cache through its port set: RE, WE, invalidate, 17-bit address, 64-bit fill data, hit, 32-bit read data.
- Policy is write-through and no-write-allocate; a read miss fills one full line.
- Stalls the pipeline through ready until each access completes.

Parameters:
- BASE_ADDR, 1024: byte address subtracted from CPU addresses before mapping.
- CADDR_W, 17: cache word-address width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- mem_r_en  in  1  MEM-stage load request.
- mem_w_en  in  1  MEM-stage store request.
- mem_addr  in  32  byte address.
- mem_wdata  in  32  store data.
- mem_rdata  out  32  load data.
- ready  out  1  access complete; 0 stalls the pipeline.
- cache_addr  out  17  to cache address.
- cache_re  out  1  cache read enable (LRU update).
- cache_we  out  1  cache line fill.
- cache_inv  out  1  cache checkInvalidation.
- cache_wdata  out  64  fill line, {word1, word0}.
- cache_hit  in  1  from cache.
- cache_rdata  in  32  from cache.
- sram_req  out  1  SRAM access request.
- sram_we  out  1  SRAM write when sram_req is high.
- sram_addr  out  17  SRAM word address.
- sram_wdata  out  32  SRAM write data.
- sram_rdata  in  64  SRAM line data, valid with sram_ready.
- sram_ready  in  1  one-cycle completion pulse.

Behaviour:
- Address map: cache_addr = (mem_addr - BASE_ADDR)[18:2], combinational in IDLE and taken from the latched address otherwise. Bit 0 is the word offset within the line.
- sram_addr is the latched cache_addr. For reads, bit 0 is forced to 0 so the whole line is fetched.
- Reset: state=IDLE. Latched addr, data and line registers are cleared to 0. All outputs are 0 except ready.
- ready in IDLE is 1 when mem_r_en=mem_w_en=0.
- FSM states: IDLE, RD_WAIT, FILL, WR_WAIT.
- IDLE, read:
  - cache_re = mem_r_en.
  - Hit: mem_rdata=cache_rdata and ready=1 in the same cycle (0 extra latency); stay in IDLE.
  - Miss: ready=0; latch the address; go to RD_WAIT.
- IDLE, write:
  - cache_inv=1 for one cycle; ready=0.
  - Latch the address and data; go to WR_WAIT.
- If mem_w_en and mem_r_en are both high, the write wins. cache_re stays 0 in that cycle.
- RD_WAIT:
  - sram_req=1, sram_we=0, ready=0.
  - On sram_ready: register sram_rdata into the line register; go to FILL.
- FILL:
  - cache_we=1 and cache_wdata=line register.
  - mem_rdata = line[63:32] if latched offset=1, else line[31:0].
  - ready=1; go to IDLE.
  - Exactly one cycle long.
- WR_WAIT:
  - sram_req=1, sram_we=1, sram_wdata=latched data, ready=0.
  - On sram_ready: ready=1 in that same cycle; go to IDLE.
- sram_req stays high continuously until sram_ready. No new request is issued in the cycle after completion, because the FSM returns to IDLE.
- The pipeline is assumed to advance on any clock edge where ready=1. The requests seen in the following IDLE cycle are new accesses.
- An sram_ready pulse arriving in IDLE or FILL is ignored.
- mem_rdata is 0 whenever ready=0 or the access is not a load.
- Reset mid-operation (RD_WAIT or WR_WAIT): IDLE on the next edge and sram_req drops. The partial access is discarded.

Optional Feature:
- Macro CACHE_CTRL_STATS_EN.
- When defined:
  - Adds outputs hit_count (32) and miss_count (32).
  - hit_count increments on each IDLE read hit.
  - miss_count increments on each IDLE read-miss entry.
  - Both are cleared by rst and saturate at 32'hFFFF_FFFF.
- When undefined: the ports and counters do not exist, and the remaining behaviour is identical.

Decomposition:
- Shared package cache_pkg holds:
  - state enum {IDLE, RD_WAIT, FILL, WR_WAIT};
  - CADDR_W, LINE_W=64, WORD_W=32;
  - BASE_ADDR default.
- One natural sub-module, cache_addr_map: the combinational byte-to-word address translation, reused by the SRAM controller.
- FSM and datapath stay in cache_controller.

Test Plan:
- Read hit, zero latency:
  - Stimulus: mem_r_en=1, mem_addr=1024+8, cache_hit=1, cache_rdata=32'hDEADBEEF.
  - Response: same cycle ready=1, mem_rdata=DEADBEEF, cache_addr=2, cache_re=1, sram_req=0.
- Read miss then fill:
  - Stimulus: mem_addr=1024+12, cache_hit=0; sram_ready after 3 cycles with sram_rdata=64'h11112222_33334444.
  - Response: sram_req=1 with sram_addr=2 for those 3 cycles; next cycle (FILL) has cache_we=1, cache_wdata equal to the line, mem_rdata=32'h11112222, ready=1; then IDLE.
- Write-through:
  - Stimulus: mem_w_en=1, mem_addr=1024+4, mem_wdata=5A5A5A5A; SRAM responds after 2 cycles.
  - Response: first cycle cache_inv=1, ready=0; then sram_req=sram_we=1 with sram_addr=1 and sram_wdata=5A5A5A5A; ready=1 in the sram_ready cycle; cache_we never asserts.
- Simultaneous requests:
  - Stimulus: mem_r_en=mem_w_en=1.
  - Response: handled as a write (cache_inv=1, cache_re=0).
- Reset mid-operation:
  - Stimulus: rst=1 during RD_WAIT.
  - Response: next cycle sram_req=0, ready=1, state IDLE; a late sram_ready is ignored with no cache_we.
- Counters (CACHE_CTRL_STATS_EN defined):
  - Stimulus: 3 hits and 2 misses.
  - Response: hit_count=3, miss_count=2; rst clears both to 0.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and constants for the data-cache controller.
package cache_pkg;

  localparam int unsigned CADDR_W   = 17;
  localparam int unsigned LINE_W    = 64;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned BASE_ADDR = 1024;

  typedef enum logic [1:0] {
    StIdle,
    StRdWait,
    StFill,
    StWrWait
  } state_e;

endpackage

// File: rtl/cache_addr_map.sv
// Byte-address to cache word-address translation, shared with the SRAM controller.
module cache_addr_map #(
  parameter int unsigned BASE_ADDR = cache_pkg::BASE_ADDR,
  parameter int unsigned CADDR_W   = cache_pkg::CADDR_W
) (
  input  logic [31:0]        byte_addr_i,
  output logic [CADDR_W-1:0] word_addr_o
);

  logic [31:0] offset;
  logic        unused_bits;

  assign offset      = byte_addr_i - BASE_ADDR;
  assign word_addr_o = offset[CADDR_W+1:2];
  // Byte-lane and out-of-range bits are intentionally dropped.
  assign unused_bits = ^{offset[31:CADDR_W+2], offset[1:0]};

endmodule

// File: rtl/cache_controller.sv
// Write-through, no-write-allocate controller between the MEM stage, data cache and SRAM.
// Optional hit/miss statistics counters are enabled with CACHE_CTRL_STATS_EN.
module cache_controller #(
  parameter int unsigned BASE_ADDR = cache_pkg::BASE_ADDR,
  parameter int unsigned CADDR_W   = cache_pkg::CADDR_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          mem_r_en,
  input  logic                          mem_w_en,
  input  logic [31:0]                   mem_addr,
  input  logic [cache_pkg::WORD_W-1:0]  mem_wdata,
  output logic [cache_pkg::WORD_W-1:0]  mem_rdata,
  output logic                          ready,
  output logic [CADDR_W-1:0]            cache_addr,
  output logic                          cache_re,
  output logic                          cache_we,
  output logic                          cache_inv,
  output logic [cache_pkg::LINE_W-1:0]  cache_wdata,
  input  logic                          cache_hit,
  input  logic [cache_pkg::WORD_W-1:0]  cache_rdata,
  output logic                          sram_req,
  output logic                          sram_we,
  output logic [CADDR_W-1:0]            sram_addr,
  output logic [cache_pkg::WORD_W-1:0]  sram_wdata,
  input  logic [cache_pkg::LINE_W-1:0]  sram_rdata,
  input  logic                          sram_ready
`ifdef CACHE_CTRL_STATS_EN
  ,
  output logic [31:0]                   hit_count,
  output logic [31:0]                   miss_count
`endif
);

  import cache_pkg::*;

  state_e              state_q, state_d;
  logic [CADDR_W-1:0]  addr_q, addr_d;
  logic [WORD_W-1:0]   data_q, data_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [CADDR_W-1:0]  map_addr;
  logic                latch_rd, latch_wr, line_ld;
  logic                rd_hit, rd_miss;

  cache_addr_map #(
    .BASE_ADDR(BASE_ADDR),
    .CADDR_W  (CADDR_W)
  ) u_addr_map (
    .byte_addr_i(mem_addr),
    .word_addr_o(map_addr)
  );

  assign cache_addr  = (state_q == StIdle) ? map_addr : addr_q;
  // Reads fetch the whole line, so the word offset is masked off toward SRAM.
  assign sram_addr   = (state_q == StWrWait) ? addr_q : {addr_q[CADDR_W-1:1], 1'b0};
  assign sram_wdata  = data_q;
  assign cache_wdata = line_q;

  always_comb begin
    state_d   = state_q;
    ready     = 1'b0;
    mem_rdata = '0;
    cache_re  = 1'b0;
    cache_we  = 1'b0;
    cache_inv = 1'b0;
    sram_req  = 1'b0;
    sram_we   = 1'b0;
    latch_rd  = 1'b0;
    latch_wr  = 1'b0;
    line_ld   = 1'b0;
    rd_hit    = 1'b0;
    rd_miss   = 1'b0;
    case (state_q)
      StIdle: begin
        if (mem_w_en) begin
          cache_inv = 1'b1;
          latch_wr  = 1'b1;
          state_d   = StWrWait;
        end else if (mem_r_en) begin
          cache_re = 1'b1;
          if (cache_hit) begin
            rd_hit    = 1'b1;
            ready     = 1'b1;
            mem_rdata = cache_rdata;
          end else begin
            rd_miss  = 1'b1;
            latch_rd = 1'b1;
            state_d  = StRdWait;
          end
        end else begin
          ready = 1'b1;
        end
      end
      StRdWait: begin
        sram_req = 1'b1;
        if (sram_ready) begin
          line_ld = 1'b1;
          state_d = StFill;
        end
      end
      StFill: begin
        cache_we  = 1'b1;
        ready     = 1'b1;
        mem_rdata = addr_q[0] ? line_q[LINE_W-1:WORD_W] : line_q[WORD_W-1:0];
        state_d   = StIdle;
      end
      StWrWait: begin
        sram_req = 1'b1;
        sram_we  = 1'b1;
        if (sram_ready) begin
          ready   = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    line_d = line_q;
    if (latch_rd || latch_wr) addr_d = map_addr;
    if (latch_wr)             data_d = mem_wdata;
    if (line_ld)              line_d = sram_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      data_q  <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      line_q  <= line_d;
    end
  end

`ifdef CACHE_CTRL_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (rd_hit && (hit_cnt_q != 32'hFFFF_FFFF))   hit_cnt_d  = hit_cnt_q + 32'd1;
    if (rd_miss && (miss_cnt_q != 32'hFFFF_FFFF)) miss_cnt_d = miss_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  logic unused_stats;
  assign unused_stats = rd_hit ^ rd_miss;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench: transaction-level model of the SRAM contents and access timing.
module tb_cache_controller;

  localparam int unsigned Base = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_r_en, mem_w_en;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        ready;
  logic [16:0] cache_addr;
  logic        cache_re, cache_we, cache_inv;
  logic [63:0] cache_wdata;
  logic        cache_hit;
  logic [31:0] cache_rdata;
  logic        sram_req, sram_we;
  logic [16:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [63:0] sram_rdata;
  logic        sram_ready;
`ifdef CACHE_CTRL_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  int checks = 0;
  int errors = 0;
  int hits_m = 0;
  int misses_m = 0;
  logic [63:0] sram_mem [int];

  always #5 clk = ~clk;

  cache_controller dut (
    .clk        (clk),
    .rst        (rst),
    .mem_r_en   (mem_r_en),
    .mem_w_en   (mem_w_en),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .ready      (ready),
    .cache_addr (cache_addr),
    .cache_re   (cache_re),
    .cache_we   (cache_we),
    .cache_inv  (cache_inv),
    .cache_wdata(cache_wdata),
    .cache_hit  (cache_hit),
    .cache_rdata(cache_rdata),
    .sram_req   (sram_req),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .sram_ready (sram_ready)
`ifdef CACHE_CTRL_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] wa_of(input logic [31:0] a);
    logic [31:0] t;
    t = (a - Base) / 4;
    return t[16:0];
  endfunction

  function automatic logic [63:0] model_line(input int idx);
    if (!sram_mem.exists(idx)) sram_mem[idx] = {$urandom, $urandom};
    return sram_mem[idx];
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    mem_r_en    = 1'b0;
    mem_w_en    = 1'b0;
    cache_hit   = 1'b0;
    cache_rdata = '0;
    sram_ready  = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    #1;
    check({tag, "_ready"}, 64'(ready), 64'd1);
    check({tag, "_req"}, 64'(sram_req), 64'd0);
    check({tag, "_we"}, 64'(cache_we), 64'd0);
    check({tag, "_rdata"}, 64'(mem_rdata), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    mem_addr = Base;
    tick();
    tick();
    rst = 1'b0;
    hits_m = 0;
    misses_m = 0;
  endtask

  task automatic do_hit(input logic [31:0] addr, input logic [31:0] data);
    mem_r_en    = 1'b1;
    mem_addr    = addr;
    cache_hit   = 1'b1;
    cache_rdata = data;
    #1;
    check("hit_ready", 64'(ready), 64'd1);
    check("hit_rdata", 64'(mem_rdata), 64'(data));
    check("hit_caddr", 64'(cache_addr), 64'(wa_of(addr)));
    check("hit_re", 64'(cache_re), 64'd1);
    check("hit_req", 64'(sram_req), 64'd0);
    check("hit_inv", 64'(cache_inv), 64'd0);
    hits_m++;
    tick();
    idle_inputs();
  endtask

  task automatic do_miss(input logic [31:0] addr, input int lat);
    logic [16:0] wa;
    logic [63:0] line;
    logic [31:0] word;
    wa   = wa_of(addr);
    line = model_line(int'(wa >> 1));
    word = wa[0] ? line[63:32] : line[31:0];
    mem_r_en    = 1'b1;
    mem_addr    = addr;
    cache_hit   = 1'b0;
    cache_rdata = $urandom;
    #1;
    check("miss_ready", 64'(ready), 64'd0);
    check("miss_rdata0", 64'(mem_rdata), 64'd0);
    check("miss_re", 64'(cache_re), 64'd1);
    check("miss_caddr", 64'(cache_addr), 64'(wa));
    misses_m++;
    tick();
    for (int i = 1; i <= lat; i++) begin
      sram_ready = (i == lat);
      sram_rdata = (i == lat) ? line : {$urandom, $urandom};
      #1;
      check("rdw_req", 64'(sram_req), 64'd1);
      check("rdw_swe", 64'(sram_we), 64'd0);
      check("rdw_saddr", 64'(sram_addr), 64'({wa[16:1], 1'b0}));
      check("rdw_ready", 64'(ready), 64'd0);
      check("rdw_cwe", 64'(cache_we), 64'd0);
      tick();
    end
    sram_ready = 1'($urandom_range(0, 1));
    sram_rdata = {$urandom, $urandom};
    #1;
    check("fill_cwe", 64'(cache_we), 64'd1);
    check("fill_wdata", cache_wdata, line);
    check("fill_rdata", 64'(mem_rdata), 64'(word));
    check("fill_ready", 64'(ready), 64'd1);
    check("fill_req", 64'(sram_req), 64'd0);
    check("fill_caddr", 64'(cache_addr), 64'(wa));
    tick();
    idle_inputs();
    check_idle("after_fill");
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input int lat,
                          input logic both);
    logic [16:0] wa;
    logic [63:0] line;
    int          idx;
    wa = wa_of(addr);
    mem_w_en  = 1'b1;
    mem_r_en  = both;
    mem_addr  = addr;
    mem_wdata = data;
    cache_hit = 1'($urandom_range(0, 1));
    #1;
    check("wr_inv", 64'(cache_inv), 64'd1);
    check("wr_ready", 64'(ready), 64'd0);
    check("wr_re", 64'(cache_re), 64'd0);
    check("wr_caddr", 64'(cache_addr), 64'(wa));
    check("wr_rdata", 64'(mem_rdata), 64'd0);
    tick();
    mem_wdata = ~data;
    for (int i = 1; i <= lat; i++) begin
      sram_ready = (i == lat);
      #1;
      check("wrw_req", 64'(sram_req), 64'd1);
      check("wrw_swe", 64'(sram_we), 64'd1);
      check("wrw_saddr", 64'(sram_addr), 64'(wa));
      check("wrw_wdata", 64'(sram_wdata), 64'(data));
      check("wrw_ready", 64'(ready), 64'(i == lat));
      check("wrw_cwe", 64'(cache_we), 64'd0);
      check("wrw_inv", 64'(cache_inv), 64'd0);
      check("wrw_rdata", 64'(mem_rdata), 64'd0);
      tick();
    end
    idx  = int'(wa >> 1);
    line = model_line(idx);
    if (wa[0]) line[63:32] = data;
    else       line[31:0]  = data;
    sram_mem[idx] = line;
    idle_inputs();
    check_idle("after_wr");
  endtask

  initial begin
    rst        = 1'b1;
    mem_addr   = Base;
    mem_wdata  = '0;
    sram_rdata = '0;
    idle_inputs();
    tick();
    do_reset();
    #1;
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_caddr", 64'(cache_addr), 64'd0);
    check("rst_saddr", 64'(sram_addr), 64'd0);
    check("rst_swdata", 64'(sram_wdata), 64'd0);
    check("rst_cwdata", cache_wdata, 64'd0);
    check("rst_req", 64'(sram_req), 64'd0);
    check("rst_ctl", 64'({cache_re, cache_we, cache_inv, sram_we}), 64'd0);
    check("rst_rdata", 64'(mem_rdata), 64'd0);

    do_hit(Base + 8, 32'hDEAD_BEEF);
    sram_mem[1] = 64'h1111_2222_3333_4444;
    do_miss(Base + 12, 3);
    do_write(Base + 4, 32'h5A5A_5A5A, 2, 1'b0);
    do_write(Base + 20, 32'hC0DE_0001, 1, 1'b1);
    do_miss(Base + 4, 1);

    // Spurious completion pulse while idle must not start anything.
    sram_ready = 1'b1;
    #1;
    check("spur_req", 64'(sram_req), 64'd0);
    tick();
    sram_ready = 1'b0;
    check_idle("spur_after");

    // Reset while waiting on a line fetch.
    mem_r_en  = 1'b1;
    mem_addr  = Base + 40;
    cache_hit = 1'b0;
    tick();
    #1;
    check("rstmid_req", 64'(sram_req), 64'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle_inputs();
    hits_m = 0;
    misses_m = 0;
    check_idle("rstmid_idle");
    sram_ready = 1'b1;
    sram_rdata = {$urandom, $urandom};
    tick();
    sram_ready = 1'b0;
    check_idle("rstmid_late");

    do_hit(Base, 32'h0000_0001);
    do_miss(Base + 16, 2);
    do_hit(Base + 4, 32'h0000_0002);
    do_miss(Base + 28, 1);
    do_hit(Base + 8, 32'h0000_0003);
`ifdef CACHE_CTRL_STATS_EN
    #1;
    check("stat_hits3", 64'(hit_count), 64'd3);
    check("stat_miss2", 64'(miss_count), 64'd2);
`endif

    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      a = Base + 4 * $urandom_range(0, 31);
      case ($urandom_range(0, 4))
        0: begin
          tick();
          check_idle("rnd_idle");
        end
        1: do_hit(a, $urandom);
        2: do_miss(a, $urandom_range(1, 4));
        3: do_write(a, $urandom, $urandom_range(1, 4), 1'b0);
        default: do_write(a, $urandom, $urandom_range(1, 4), 1'b1);
      endcase
    end

`ifdef CACHE_CTRL_STATS_EN
    #1;
    check("stat_hits", 64'(hit_count), 64'(hits_m));
    check("stat_miss", 64'(miss_count), 64'(misses_m));
    do_reset();
    #1;
    check("stat_hits_rst", 64'(hit_count), 64'd0);
    check("stat_miss_rst", 64'(miss_count), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
